// File: rtl/layer_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : layer_sequencer_pkg
// Description : State encoding and mode constants shared by the layer
//               sequencer and the weight pipeline controller.
// Revision    : 1.0 - initial release
// ============================================================================
package layer_sequencer_pkg;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_IDLE      = 3'd0;
    localparam seq_state_t ST_LOAD_REQ  = 3'd1;
    localparam seq_state_t ST_LOAD      = 3'd2;
    localparam seq_state_t ST_LAYER_REQ = 3'd3;
    localparam seq_state_t ST_LAYER     = 3'd4;
    localparam seq_state_t ST_GAP       = 3'd5;
    localparam seq_state_t ST_DONE      = 3'd6;

    localparam logic [2:0] MODE_IDLE  = 3'd0;
    localparam logic [2:0] MODE_LOAD  = 3'd1;
    localparam logic [2:0] MODE_LAYER = 3'd2;

    // Mode presented to the controller while the sequencer sits in a state.
    function automatic logic [2:0] state_mode(input seq_state_t st);
        logic [2:0] m;
        case (st)
            ST_LOAD_REQ, ST_LOAD:   m = MODE_LOAD;
            ST_LAYER_REQ, ST_LAYER: m = MODE_LAYER;
            default:                m = MODE_IDLE;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/layer_sequencer_timeout.sv
`default_nettype none
// ============================================================================
// Module      : seq_timeout
// Description : Handshake watchdog. Reloads while clear is high, then counts
//               down once per cycle; expired is high on the CYCLES-th cycle
//               after clear drops and stays high until the next clear.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_timeout #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic expired
);
    import layer_sequencer_pkg::*;

    localparam int              CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0]   c_load = CW'(CYCLES - 1);
    localparam logic [CW-1:0]   c_one  = CW'(1);

    logic [CW-1:0] r_count;

    // Reload on clear, otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= c_load;
        end else if (r_count != '0) begin
            r_count <= r_count - c_one;
        end
    end

    assign expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : layer_sequencer
// Description : Per-layer command sequencer for the weight pipeline
//               controller: load request, weight-word streaming, layering
//               request, compute window, one-cycle mode gap between layers.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_sequencer #(
    parameter int CNT_W     = 8,
    parameter int LYR_W     = 4,
    parameter int TO_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LYR_W-1:0] num_layers,
    input  logic [CNT_W-1:0] load_len,
    input  logic [CNT_W-1:0] layer_len,
    input  logic             load_ready,
    input  logic             layer_ready,
    output logic [2:0]       mode,
    output logic             w_valid,
    output logic [CNT_W-1:0] w_idx,
    output logic             compute_en,
    output logic [LYR_W-1:0] layer_idx,
    output logic             busy,
    output logic             done,
    output logic             err
);
    import layer_sequencer_pkg::*;

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [LYR_W-1:0] c_lyr_one = LYR_W'(1);

    seq_state_t       r_state;
    seq_state_t       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic [LYR_W-1:0] r_num_layers;
    logic [CNT_W-1:0] r_load_len;
    logic [CNT_W-1:0] r_layer_len;
    logic             w_start;
    logic             w_timeout;
    logic             w_in_req;
    logic             w_expired;

    assign w_start  = (r_state == ST_IDLE) && start;
    assign w_in_req = (r_state == ST_LOAD_REQ) || (r_state == ST_LAYER_REQ);

    // The watchdog is held in reload outside the two request states, so each
    // request visit starts a fresh window.
    seq_timeout #(
        .CYCLES (TO_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!w_in_req),
        .expired (w_expired)
    );

    // Next-state selection; a ready in the final window cycle wins over expiry.
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (num_layers == '0)    w_next = ST_DONE;
                    else if (load_len == '0) w_next = ST_LAYER_REQ;
                    else                     w_next = ST_LOAD_REQ;
                end
            end
            ST_LOAD_REQ: begin
                if (load_ready) begin
                    w_next = ST_LOAD;
                end else if (w_expired) begin
                    w_next    = ST_IDLE;
                    w_timeout = 1'b1;
                end
            end
            ST_LOAD: begin
                if (r_cnt == r_load_len - c_cnt_one) w_next = ST_LAYER_REQ;
            end
            ST_LAYER_REQ: begin
                if (layer_ready) begin
                    w_next = ST_LAYER;
                end else if (w_expired) begin
                    w_next    = ST_IDLE;
                    w_timeout = 1'b1;
                end
            end
            ST_LAYER: begin
                if (r_cnt == r_layer_len - c_cnt_one) begin
                    w_next = (layer_idx == r_num_layers - c_lyr_one) ? ST_DONE : ST_GAP;
                end
            end
            ST_GAP:  w_next = (r_load_len == '0) ? ST_LAYER_REQ : ST_LOAD_REQ;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase

        // The shared counter runs only while staying in LOAD or LAYER, so it
        // is zero on the first cycle of each of those phases.
        if ((w_next == r_state) && ((r_state == ST_LOAD) || (r_state == ST_LAYER))) begin
            w_next_cnt = r_cnt + c_cnt_one;
        end else begin
            w_next_cnt = '0;
        end
    end

    // State and word/cycle counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_next_cnt;
        end
    end

    // Run parameters captured on an accepted start; a zero compute length
    // is stored as one so the compare above needs no special case.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_num_layers <= '0;
            r_load_len   <= '0;
            r_layer_len  <= '0;
        end else if (w_start) begin
            r_num_layers <= num_layers;
            r_load_len   <= load_len;
            r_layer_len  <= (layer_len == '0) ? c_cnt_one : layer_len;
        end
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode       <= MODE_IDLE;
            w_valid    <= 1'b0;
            w_idx      <= '0;
            compute_en <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            mode       <= state_mode(w_next);
            w_valid    <= (w_next == ST_LOAD);
            w_idx      <= (w_next == ST_LOAD) ? w_next_cnt : '0;
            compute_en <= (w_next == ST_LAYER);
            busy       <= (w_next != ST_IDLE);
            done       <= (w_next == ST_DONE);
        end
    end

    // Layer index advances as the gap cycle ends; error flag is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            layer_idx <= '0;
            err       <= 1'b0;
        end else begin
            if (w_start)                 layer_idx <= '0;
            else if (r_state == ST_GAP)  layer_idx <= layer_idx + c_lyr_one;

            if (w_start)                 err <= 1'b0;
            else if (w_timeout)          err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer_sequencer
// Description : Self-checking bench for layer_sequencer. A reference model
//               expands each run into the expected per-cycle output trace;
//               a small controller model answers mode requests after a
//               chosen latency (or never, to force a timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_sequencer;

    localparam int CNT_W = 8;
    localparam int LYR_W = 4;
    localparam int TO    = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LYR_W-1:0] num_layers;
    logic [CNT_W-1:0] load_len;
    logic [CNT_W-1:0] layer_len;
    logic             load_ready;
    logic             layer_ready;
    logic [2:0]       mode;
    logic             w_valid;
    logic [CNT_W-1:0] w_idx;
    logic             compute_en;
    logic [LYR_W-1:0] layer_idx;
    logic             busy;
    logic             done;
    logic             err;

    layer_sequencer #(
        .CNT_W     (CNT_W),
        .LYR_W     (LYR_W),
        .TO_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_layers  (num_layers),
        .load_len    (load_len),
        .layer_len   (layer_len),
        .load_ready  (load_ready),
        .layer_ready (layer_ready),
        .mode        (mode),
        .w_valid     (w_valid),
        .w_idx       (w_idx),
        .compute_en  (compute_en),
        .layer_idx   (layer_idx),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       mode;
        logic             w_valid;
        logic [CNT_W-1:0] w_idx;
        logic             compute_en;
        logic [LYR_W-1:0] layer_idx;
        logic             busy;
        logic             done;
        logic             err;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   lat_load  = 1;
    int   lat_layer = 1;
    logic             m_err  = 1'b0;
    logic [LYR_W-1:0] m_lidx = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, expv);
    endtask

    // Observed outputs in the trace layout; the word index is only defined
    // while a weight strobe is expected.
    function automatic logic [31:0] observed(input exp_t e);
        exp_t o;
        o.mode       = mode;
        o.w_valid    = w_valid;
        o.w_idx      = e.w_valid ? w_idx : '0;
        o.compute_en = compute_en;
        o.layer_idx  = layer_idx;
        o.busy       = busy;
        o.done       = done;
        o.err        = err;
        return 32'(o);
    endfunction

    task automatic push(input logic [2:0] md, input logic wv, input int wi,
                        input logic ce, input logic dn);
        exp_t e;
        e.mode = md; e.w_valid = wv; e.w_idx = CNT_W'(wi); e.compute_en = ce;
        e.layer_idx = m_lidx; e.busy = 1'b1; e.done = dn; e.err = m_err;
        q.push_back(e);
    endtask

    // A request phase lasts latency+1 cycles, or TO cycles then an error.
    task automatic req_phase(input logic [2:0] md, input int lat, output bit ok);
        int d = lat + 1;
        ok = (d <= TO);
        for (int k = 0; k < (ok ? d : TO); k++) push(md, 1'b0, 0, 1'b0, 1'b0);
        if (!ok) m_err = 1'b1;
    endtask

    task automatic build(input int n, input int l, input int c, input int ll, input int lc);
        bit ok;
        q.delete();
        m_err = 1'b0; m_lidx = '0;
        if (n == 0) begin
            push(3'd0, 1'b0, 0, 1'b0, 1'b1);
            return;
        end
        for (int i = 0; i < n; i++) begin
            m_lidx = LYR_W'(i);
            if (l != 0) begin
                req_phase(3'd1, ll, ok);
                if (!ok) return;
                for (int j = 0; j < l; j++) push(3'd1, 1'b1, j, 1'b0, 1'b0);
            end
            req_phase(3'd2, lc, ok);
            if (!ok) return;
            for (int j = 0; j < ((c == 0) ? 1 : c); j++) push(3'd2, 1'b0, 0, 1'b1, 1'b0);
            if (i < n - 1) push(3'd0, 1'b0, 0, 1'b0, 1'b0);
        end
        push(3'd0, 1'b0, 0, 1'b0, 1'b1);
    endtask

    function automatic exp_t idle_entry();
        exp_t e;
        e = '0;
        e.layer_idx = m_lidx;
        e.err = m_err;
        return e;
    endfunction

    // Controller model: ready rises once the mode has been held for lat+1 cycles.
    initial begin
        logic [2:0] last_mode;
        int age;
        last_mode = 3'd7; age = 0;
        load_ready = 1'b0; layer_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (mode == last_mode) age++;
            else age = 1;
            last_mode = mode;
            load_ready  = (mode == 3'd1) && (age >= lat_load + 1);
            layer_ready = (mode == 3'd2) && (age >= lat_layer + 1);
        end
    end

    task automatic run_one(input string name, input int n, input int l, input int c,
                           input int ll, input int lc, input bit do_rst);
        build(n, l, c, ll, lc);
        lat_load = ll; lat_layer = lc;
        num_layers = LYR_W'(n); load_len = CNT_W'(l); layer_len = CNT_W'(c);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < q.size(); k++) begin
            check($sformatf("%s cyc%0d", name, k), observed(q[k]), 32'(q[k]));
            if (do_rst && q[k].compute_en) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check($sformatf("%s rst", name), observed(q[k]) & 32'hFFFFF, 32'h0);
                m_err = 1'b0; m_lidx = '0;
                break;
            end
            // Start and length changes while busy must not disturb the run.
            start      = q[k].busy && ($urandom_range(0, 3) == 0);
            num_layers = LYR_W'($urandom);
            load_len   = CNT_W'($urandom);
            layer_len  = CNT_W'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s idle%0d", name, k), observed(idle_entry()), 32'(idle_entry()));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int r, n, l, c, ll, lc;
        rst = 1'b1; start = 1'b0;
        num_layers = '0; load_len = '0; layer_len = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", observed(idle_entry()), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_one("nominal",   2, 3,   4, 1,   1,  1'b0);
        run_one("reuse",     3, 0,   2, 1,   2,  1'b0);
        run_one("empty",     0, 3,   4, 1,   1,  1'b0);
        run_one("to_load",   1, 3,   4, 100, 1,  1'b0);
        run_one("clear_err", 1, 2,   2, 2,   1,  1'b0);
        run_one("ready_lim", 1, 2,   2, 15,  15, 1'b0);
        run_one("to_layer",  2, 2,   2, 1,   16, 1'b0);
        run_one("len_zero",  2, 1,   0, 1,   1,  1'b0);
        run_one("len_max",   1, 255, 255, 1, 1,  1'b0);
        run_one("mid_rst",   2, 2,   6, 1,   1,  1'b1);

        for (int i = 0; i < 25; i++) begin
            n  = $urandom_range(0, 3);
            l  = $urandom_range(0, 5);
            c  = $urandom_range(0, 5);
            r  = $urandom_range(0, 9);
            ll = (r == 0) ? 16 : $urandom_range(1, 3);
            r  = $urandom_range(0, 9);
            lc = (r == 0) ? 16 : $urandom_range(1, 3);
            run_one($sformatf("rand%0d", i), n, l, c, ll, lc, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
